// File: rtl/core_quant_pack.sv
// core_quant_pack: requantizes signed accumulator results (bias, scale,
// rounding shift, saturation), packs PACK_NUM elements per word and buffers
// the words in a small FIFO toward the writeback stage. The upstream side
// has no backpressure, so a word that finds the FIFO full is dropped and
// reported through the sticky overflow_flag.
module core_quant_pack #(
    parameter int IDATA_WIDTH = 32,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int ODATA_BIT   = 8,
    parameter int PACK_NUM    = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [IDATA_WIDTH-1:0]        cfg_bias,
    input  logic [SCALE_WIDTH-1:0]        cfg_scale,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic                          cfg_clr,
    input  logic [IDATA_WIDTH-1:0]        idata,
    input  logic                          idata_valid,
    input  logic                          idata_last,
    output logic [ODATA_BIT*PACK_NUM-1:0] odata,
    output logic                          odata_valid,
    input  logic                          odata_ready,
    output logic [$clog2(PACK_NUM):0]     odata_lanes,
    output logic                          overflow_flag
);

    localparam int SUM_W  = IDATA_WIDTH + 1;
    localparam int PROD_W = SUM_W + SCALE_WIDTH;
    localparam int RND_W  = PROD_W + 1;
    localparam int WORD_W = ODATA_BIT * PACK_NUM;
    localparam int LANE_W = $clog2(PACK_NUM);
    localparam int CNT_W  = LANE_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    localparam logic signed [RND_W-1:0] Q_MAX = RND_W'((1 << (ODATA_BIT - 1)) - 1);
    localparam logic signed [RND_W-1:0] Q_MIN = -Q_MAX - RND_W'(1);

    // ---------------- pipeline ----------------
    logic                     s1_valid, s1_last;
    logic signed [SUM_W-1:0]  s1_sum;
    logic                     s2_valid, s2_last;
    logic signed [PROD_W-1:0] s2_prod;
    logic                     s3_valid, s3_last;
    logic [ODATA_BIT-1:0]     s3_q;

    logic signed [RND_W-1:0]  prod_ext, rnd_add, rounded;
    logic [ODATA_BIT-1:0]     q_sat;

    // Stage 1: add bias at full width so the sum cannot wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= idata_valid;
            s1_last  <= idata_valid && idata_last;
            s1_sum   <= SUM_W'($signed(idata)) + SUM_W'($signed(cfg_bias));
        end
    end

    // Stage 2: full-precision signed multiply by the scale
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_prod  <= PROD_W'(s1_sum) * PROD_W'($signed(cfg_scale));
        end
    end

    // Round half toward +inf via arithmetic shift, then clamp to the output range
    always_comb begin
        prod_ext = RND_W'(s2_prod);
        rnd_add  = '0;
        if (cfg_shift != '0)
            rnd_add = RND_W'(1) << (cfg_shift - SHIFT_WIDTH'(1));
        rounded = (prod_ext + rnd_add) >>> cfg_shift;
        if (rounded > Q_MAX)
            q_sat = Q_MAX[ODATA_BIT-1:0];
        else if (rounded < Q_MIN)
            q_sat = Q_MIN[ODATA_BIT-1:0];
        else
            q_sat = rounded[ODATA_BIT-1:0];
    end

    // Stage 3: register the quantized element
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_q     <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_q     <= q_sat;
        end
    end

    // ---------------- packer ----------------
    logic [WORD_W-1:0] stage_word, word_next;
    logic [LANE_W-1:0] lane_cnt;
    logic              push_req;
    logic [CNT_W-1:0]  push_lanes;

    // Merge the current element into the staging word and decide whether it closes
    always_comb begin
        word_next = stage_word;
        word_next[lane_cnt*ODATA_BIT +: ODATA_BIT] = s3_q;
        push_req   = s3_valid && (s3_last || (lane_cnt == LANE_W'(PACK_NUM - 1)));
        push_lanes = CNT_W'(lane_cnt) + CNT_W'(1);
    end

    // Staging word and lane counter; a closed word leaves upper lanes zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_word <= '0;
            lane_cnt   <= '0;
        end else if (s3_valid) begin
            if (push_req) begin
                stage_word <= '0;
                lane_cnt   <= '0;
            end else begin
                stage_word <= word_next;
                lane_cnt   <= lane_cnt + LANE_W'(1);
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [WORD_W-1:0] mem_word  [FIFO_DEPTH];
    logic [CNT_W-1:0]  mem_lanes [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  count;
    logic              full, pop, push, drop;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    always_comb begin
        full = (count == OCC_W'(FIFO_DEPTH));
        pop  = (count != '0) && odata_ready;
        push = push_req && (!full || pop);
        drop = push_req && full && !pop;
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_word[i]  <= '0;
                mem_lanes[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_word[wr_ptr]  <= word_next;
                mem_lanes[wr_ptr] <= push_lanes;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + OCC_W'(1);
            else if (pop && !push)
                count <= count - OCC_W'(1);
        end
    end

    // Sticky drop indicator; a new drop outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            overflow_flag <= 1'b0;
        else if (drop)
            overflow_flag <= 1'b1;
        else if (cfg_clr)
            overflow_flag <= 1'b0;
    end

    assign odata       = mem_word[rd_ptr];
    assign odata_lanes = mem_lanes[rd_ptr];
    assign odata_valid = (count != '0);

endmodule

// File: tb/tb_core_quant_pack.sv
// Testbench for core_quant_pack: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_core_quant_pack;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] cfg_bias;
    logic [15:0] cfg_scale;
    logic [4:0]  cfg_shift;
    logic        cfg_clr;
    logic [31:0] idata;
    logic        idata_valid;
    logic        idata_last;
    logic [31:0] odata;
    logic        odata_valid;
    logic        odata_ready;
    logic [2:0]  odata_lanes;
    logic        overflow_flag;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        int unsigned at;
        logic [31:0] w;
        logic [2:0]  l;
    } pend_t;

    core_quant_pack #(
        .IDATA_WIDTH(32),
        .SCALE_WIDTH(16),
        .SHIFT_WIDTH(5),
        .ODATA_BIT(8),
        .PACK_NUM(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_bias(cfg_bias),
        .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift),
        .cfg_clr(cfg_clr),
        .idata(idata),
        .idata_valid(idata_valid),
        .idata_last(idata_last),
        .odata(odata),
        .odata_valid(odata_valid),
        .odata_ready(odata_ready),
        .odata_lanes(odata_lanes),
        .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Reference quantizer: integer arithmetic straight from the rules
    function automatic logic [7:0] ref_quant(input logic [31:0] x, input logic [31:0] b,
                                             input logic [15:0] s, input logic [4:0] sh);
        longint sum, prod, r;
        sum  = longint'($signed(x)) + longint'($signed(b));
        prod = sum * longint'($signed(s));
        if (sh == 5'd0) r = prod;
        else            r = (prod + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 127)       r = 127;
        else if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic logic [31:0] seq_word(input int unsigned i);
        logic [31:0] w;
        for (int unsigned j = 0; j < 4; j++) w[8*j +: 8] = 8'(16*i + j + 1);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic l);
        idata_valid = 1'b1;
        idata       = d;
        idata_last  = l;
        tick();
        idata_valid = 1'b0;
        idata_last  = 1'b0;
    endtask

    task automatic drive_seq_word(input int unsigned i);
        for (int unsigned j = 0; j < 4; j++) drive(32'(16*i + j + 1), 1'b0);
    endtask

    task automatic set_cfg(input logic [31:0] b, input logic [15:0] s, input logic [4:0] sh);
        cfg_bias  = b;
        cfg_scale = s;
        cfg_shift = sh;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        idata_valid = 1'b0;
        idata_last  = 1'b0;
        cfg_clr     = 1'b0;
        odata_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // One element closed by last; returns what the FIFO head shows 4 edges later
    task automatic run_single(input logic [31:0] b, input logic [15:0] s, input logic [4:0] sh,
                              input logic [31:0] d, output logic v, output logic [31:0] w,
                              output logic [2:0] ln);
        set_cfg(b, s, sh);
        odata_ready = 1'b0;
        drive(d, 1'b1);
        tick();
        tick();
        tick();
        v  = odata_valid;
        w  = odata;
        ln = odata_lanes;
        odata_ready = 1'b1;
        tick();
        odata_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        idata_valid = 1'b0;
        idata_last  = 1'b0;
        idata       = '0;
        cfg_clr     = 1'b0;
        odata_ready = 1'b0;
        set_cfg(32'd0, 16'd1, 5'd0);
        tick();
        n_total++; if (odata_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", odata_valid); else n_pass++;
        n_total++; if (odata !== 32'h0) $display("FAIL reset_odata: got %h want 00000000", odata); else n_pass++;
        n_total++; if (odata_lanes !== 3'd0) $display("FAIL reset_lanes: got %0d want 0", odata_lanes); else n_pass++;
        n_total++; if (overflow_flag !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_flag); else n_pass++;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic_pack();
        do_reset();
        set_cfg(32'd0, 16'd1, 5'd0);
        for (int unsigned j = 1; j <= 4; j++) drive(32'(j), 1'b0);
        for (int unsigned k = 0; k < 3; k++) begin
            n_total++; if (odata_valid !== 1'b0) $display("FAIL basic_early_valid[%0d]: got %b want 0", k, odata_valid); else n_pass++;
            tick();
        end
        n_total++; if (odata_valid !== 1'b1) $display("FAIL basic_latency: got %b want 1", odata_valid); else n_pass++;
        n_total++; if (odata !== 32'h04030201) $display("FAIL basic_word: got %h want 04030201", odata); else n_pass++;
        n_total++; if (odata_lanes !== 3'd4) $display("FAIL basic_lanes: got %0d want 4", odata_lanes); else n_pass++;
        odata_ready = 1'b1;
        tick();
        odata_ready = 1'b0;
        n_total++; if (odata_valid !== 1'b0) $display("FAIL basic_pop: got %b want 0", odata_valid); else n_pass++;
    endtask

    task automatic test_round_bias();
        logic [31:0] tb_b [3] = '{32'd0, 32'd0, 32'hFFFF_FFF6};
        logic [15:0] tb_s [3] = '{16'd3, 16'd1, 16'd1};
        logic [4:0]  tb_h [3] = '{5'd4, 5'd4, 5'd0};
        logic [31:0] tb_d [3] = '{32'd300, 32'hFFFF_FFE8, 32'd14};
        logic [31:0] tb_e [3] = '{32'h38, 32'hFF, 32'h04};
        logic v;
        logic [31:0] w;
        logic [2:0] ln;
        do_reset();
        for (int unsigned i = 0; i < 3; i++) begin
            run_single(tb_b[i], tb_s[i], tb_h[i], tb_d[i], v, w, ln);
            n_total++; if (v !== 1'b1) $display("FAIL round_valid[%0d]: got %b want 1", i, v); else n_pass++;
            n_total++; if (w !== tb_e[i]) $display("FAIL round_word[%0d]: got %h want %h", i, w, tb_e[i]); else n_pass++;
            n_total++; if (ln !== 3'd1) $display("FAIL round_lanes[%0d]: got %0d want 1", i, ln); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] tb_s [4] = '{16'd1, 16'd1, 16'h7FFF, 16'h7FFF};
        logic [31:0] tb_d [4] = '{32'd1000, 32'hFFFF_FC18, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] tb_e [4] = '{32'h7F, 32'h80, 32'h7F, 32'h80};
        logic v;
        logic [31:0] w;
        logic [2:0] ln;
        do_reset();
        for (int unsigned i = 0; i < 4; i++) begin
            run_single(32'd0, tb_s[i], 5'd0, tb_d[i], v, w, ln);
            n_total++; if (v !== 1'b1) $display("FAIL sat_valid[%0d]: got %b want 1", i, v); else n_pass++;
            n_total++; if (w !== tb_e[i]) $display("FAIL sat_word[%0d]: got %h want %h", i, w, tb_e[i]); else n_pass++;
        end
    endtask

    task automatic test_early_close();
        do_reset();
        set_cfg(32'd0, 16'd1, 5'd0);
        drive(32'h11, 1'b0);
        drive(32'h22, 1'b0);
        drive(32'h33, 1'b1);
        drive(32'h44, 1'b0);
        drive(32'h55, 1'b0);
        drive(32'h66, 1'b0);
        drive(32'h77, 1'b0);
        tick();
        tick();
        tick();
        n_total++; if (odata_valid !== 1'b1) $display("FAIL early_valid: got %b want 1", odata_valid); else n_pass++;
        n_total++; if (odata !== 32'h00332211) $display("FAIL early_word0: got %h want 00332211", odata); else n_pass++;
        n_total++; if (odata_lanes !== 3'd3) $display("FAIL early_lanes0: got %0d want 3", odata_lanes); else n_pass++;
        odata_ready = 1'b1;
        tick();
        n_total++; if (odata !== 32'h77665544) $display("FAIL early_word1: got %h want 77665544", odata); else n_pass++;
        n_total++; if (odata_lanes !== 3'd4) $display("FAIL early_lanes1: got %0d want 4", odata_lanes); else n_pass++;
        tick();
        n_total++; if (odata_valid !== 1'b0) $display("FAIL early_drained: got %b want 0", odata_valid); else n_pass++;
        odata_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        set_cfg(32'd0, 16'd1, 5'd0);
        for (int unsigned i = 0; i < 5; i++) drive_seq_word(i);
        for (int unsigned k = 0; k < 4; k++) tick();
        n_total++; if (overflow_flag !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_flag); else n_pass++;
        odata_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            n_total++; if (odata_valid !== 1'b1) $display("FAIL ovf_valid[%0d]: got %b want 1", i, odata_valid); else n_pass++;
            n_total++; if (odata !== seq_word(i)) $display("FAIL ovf_order[%0d]: got %h want %h", i, odata, seq_word(i)); else n_pass++;
            tick();
        end
        n_total++; if (odata_valid !== 1'b0) $display("FAIL ovf_fifth_absent: got %b want 0", odata_valid); else n_pass++;
        n_total++; if (overflow_flag !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_flag); else n_pass++;
        odata_ready = 1'b0;
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        n_total++; if (overflow_flag !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow_flag); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        do_reset();
        set_cfg(32'd0, 16'd1, 5'd0);
        for (int unsigned i = 0; i < 5; i++) drive_seq_word(i);
        tick();
        tick();
        odata_ready = 1'b1;
        tick();
        odata_ready = 1'b0;
        tick();
        n_total++; if (overflow_flag !== 1'b0) $display("FAIL pp_no_drop: got %b want 0", overflow_flag); else n_pass++;
        odata_ready = 1'b1;
        for (int unsigned i = 1; i < 5; i++) begin
            n_total++; if (odata !== seq_word(i)) $display("FAIL pp_order[%0d]: got %h want %h", i, odata, seq_word(i)); else n_pass++;
            tick();
        end
        n_total++; if (odata_valid !== 1'b0) $display("FAIL pp_drained: got %b want 0", odata_valid); else n_pass++;
        odata_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        set_cfg(32'd0, 16'd1, 5'd0);
        drive_seq_word(0);
        drive(32'h55, 1'b0);
        drive(32'h66, 1'b0);
        for (int unsigned k = 0; k < 4; k++) tick();
        n_total++; if (odata_valid !== 1'b1) $display("FAIL midrst_queued: got %b want 1", odata_valid); else n_pass++;
        rstn = 1'b0;
        #1;
        n_total++; if (odata_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", odata_valid); else n_pass++;
        n_total++; if (overflow_flag !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", overflow_flag); else n_pass++;
        tick();
        rstn = 1'b1;
        tick();
        drive(32'h0A, 1'b0);
        drive(32'h0B, 1'b0);
        drive(32'h0C, 1'b0);
        drive(32'h0D, 1'b0);
        tick();
        tick();
        tick();
        n_total++; if (odata !== 32'h0D0C0B0A) $display("FAIL midrst_word: got %h want 0D0C0B0A", odata); else n_pass++;
        n_total++; if (odata_lanes !== 3'd4) $display("FAIL midrst_lanes: got %0d want 4", odata_lanes); else n_pass++;
        odata_ready = 1'b1;
        tick();
        n_total++; if (odata_valid !== 1'b0) $display("FAIL midrst_single: got %b want 0", odata_valid); else n_pass++;
        odata_ready = 1'b0;
    endtask

    // Randomized traffic against a timestamped queue model of pack + FIFO
    task automatic test_random();
        logic [31:0] mq_w [$];
        logic [2:0]  mq_l [$];
        pend_t       pq [$];
        pend_t       p;
        logic [31:0] st_w;
        int unsigned st_n;
        int unsigned e;
        logic        m_ovf, v, l, rdy, clr, pop, full, drop;
        logic [31:0] d;
        int unsigned n_el;
        for (int unsigned round = 0; round < 3; round++) begin
            do_reset();
            set_cfg(32'(int'($urandom_range(0, 200)) - 100),
                    16'(int'($urandom_range(0, 600)) - 300),
                    5'($urandom_range(0, 12)));
            mq_w.delete(); mq_l.delete(); pq.delete();
            st_w = '0; st_n = 0; e = 0; m_ovf = 1'b0;
            n_el = 150;
            for (int unsigned cyc = 0; cyc < n_el + 12; cyc++) begin
                v   = (cyc < n_el) && (($urandom_range(0, 3) != 0) || cyc == n_el - 1);
                l   = v && (($urandom_range(0, 7) == 0) || cyc == n_el - 1);
                d   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'(int'($urandom_range(0, 2000)) - 1000);
                rdy = (cyc >= n_el) || ($urandom_range(0, 2) != 0);
                clr = (cyc < n_el) && ($urandom_range(0, 15) == 0);
                idata_valid = v; idata_last = l; idata = d;
                odata_ready = rdy; cfg_clr = clr;
                n_total++; if (odata_valid !== (mq_w.size() != 0)) $display("FAIL rnd_valid[r%0d c%0d]: got %b want %b", round, cyc, odata_valid, mq_w.size() != 0); else n_pass++;
                if (mq_w.size() != 0) begin
                    n_total++; if (odata !== mq_w[0]) $display("FAIL rnd_word[r%0d c%0d]: got %h want %h", round, cyc, odata, mq_w[0]); else n_pass++;
                    n_total++; if (odata_lanes !== mq_l[0]) $display("FAIL rnd_lanes[r%0d c%0d]: got %0d want %0d", round, cyc, odata_lanes, mq_l[0]); else n_pass++;
                end
                n_total++; if (overflow_flag !== m_ovf) $display("FAIL rnd_ovf[r%0d c%0d]: got %b want %b", round, cyc, overflow_flag, m_ovf); else n_pass++;
                // model effects of the coming edge
                pop  = (mq_w.size() != 0) && rdy;
                full = (mq_w.size() == 4);
                drop = 1'b0;
                if (pop) begin
                    void'(mq_w.pop_front());
                    void'(mq_l.pop_front());
                end
                if (pq.size() != 0 && pq[0].at == e) begin
                    p = pq.pop_front();
                    if (!full || pop) begin
                        mq_w.push_back(p.w);
                        mq_l.push_back(p.l);
                    end else drop = 1'b1;
                end
                if (drop)     m_ovf = 1'b1;
                else if (clr) m_ovf = 1'b0;
                if (v) begin
                    st_w[8*st_n +: 8] = ref_quant(d, cfg_bias, cfg_scale, cfg_shift);
                    if (st_n == 3 || l) begin
                        p.at = e + 3; p.w = st_w; p.l = 3'(st_n + 1);
                        pq.push_back(p);
                        st_w = '0; st_n = 0;
                    end else st_n++;
                end
                tick();
                e++;
            end
            idata_valid = 1'b0; idata_last = 1'b0; cfg_clr = 1'b0; odata_ready = 1'b0;
            n_total++; if (odata_valid !== 1'b0) $display("FAIL rnd_drained[r%0d]: got %b want 0", round, odata_valid); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_round_bias();
        test_saturation();
        test_early_close();
        test_overflow();
        test_push_pop_full();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
